mul_frame_engine: RTL
=====================

Name: mul_frame_engine

Overview:
- Parametrised successor to the fixed 8x8 multiply core.
- Byte-stream front end: operands arrive as bytes from an abstract link; the UART or SPI adapter sits outside this block.
- Internal sequential shift-add multiplier with unsigned/signed operand modes and multiply or multiply-accumulate operation.
- Transmits the result LSB-first over a ready/start byte link, with an inter-byte gap, receive timeout and sticky error flags.

Parameters:
- OP_WIDTH, 8: operand width in bits. Must be a multiple of 8 and at least 8. OP_BYTES = OP_WIDTH/8.
- ACC_GUARD, 8: accumulator guard bits. Must be a multiple of 8 and at least 0. ACC_WIDTH = 2*OP_WIDTH + ACC_GUARD.
- DELAY_CYCLES, 100: idle cycles between the last received byte and the start of the multiply.
- TX_GAP, 1000: idle cycles between transmitted bytes.
- RX_TIMEOUT, 50000: maximum cycles allowed between operand bytes. 0 disables the timeout.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-low reset
- mul_enable  in  1  start a transaction from IDLE
- mode  in  2  [0]=0 multiply, 1 multiply-accumulate; [1]=0 unsigned, 1 two's-complement signed
- acc_clear  in  1  zero the accumulator (honoured in IDLE only)
- rx_valid  in  1  link byte valid (level); rising edge = new byte
- rx_data  in  8  received byte
- tx_ready  in  1  link transmitter idle
- tx_start  out  1  one-cycle transmit request
- tx_data  out  8  byte to transmit, held stable from the tx_start cycle until the byte completes
- frames_received  out  1  high from completion of operand reception until return to IDLE
- busy  out  1  high in every state except IDLE
- result  out  ACC_WIDTH  last product (zero-extended in unsigned multiply, sign-extended in signed multiply) or accumulator value
- result_valid  out  1  one-cycle pulse when result updates
- acc_overflow  out  1  sticky; cleared by acc_clear or reset
- err_timeout  out  1  sticky; cleared on exit from IDLE
- err_overrun  out  1  sticky; cleared on exit from IDLE

Behaviour:
- Reset (reset=0 at a clk edge): state=IDLE.
  - All outputs 0; accumulator 0.
  - rx_valid edge register loads the current rx_valid, so a level already high is not treated as a byte.
  - Reset mid-transaction aborts immediately with no partial transmission.
- IDLE:
  - acc_clear=1 zeroes the accumulator and acc_overflow.
  - mul_enable=1 latches mode, clears the error flags, goes to RX.
  - If acc_clear and mul_enable are high together, the clear takes effect first.
  - mode changes after this latch are ignored until the next IDLE.
- RX:
  - Each rx_valid rising edge stores rx_data at the next byte index, 0..2*OP_BYTES-1.
  - Bytes 0..OP_BYTES-1 form operand A, LSB first; the remaining bytes form B, LSB first.
  - After the last byte: frames_received<=1, go to DELAY.
  - Timeout counter resets on each byte and runs only once at least one byte has been received.
  - Reaching RX_TIMEOUT sets err_timeout, discards the partial operands, sets the index to 0 and stays in RX.
- DELAY: exactly DELAY_CYCLES cycles, then MUL.
- MUL:
  - Signed mode: operands are converted to magnitudes on entry and the sign is XOR-ed.
  - Shift-add, one multiplier bit per cycle, exactly OP_WIDTH cycles.
  - Then one SIGN cycle: negate the 2*OP_WIDTH product if the sign is negative.
  - MUL-to-ACC latency is therefore OP_WIDTH+1 cycles.
- ACC, one cycle:
  - Multiply mode: result = product, extended to ACC_WIDTH.
  - Multiply-accumulate mode: accumulator += extended product, modulo 2^ACC_WIDTH; result = new accumulator.
  - Overflow: unsigned carry-out, or signed overflow (operands' signs equal and the sum's sign differs), sets acc_overflow.
  - result_valid pulses; go to TX.
- TX byte count: 2*OP_BYTES in multiply mode, ACC_WIDTH/8 in multiply-accumulate mode. Bytes are sent LSB first.
- TX per byte:
  - TX_LOAD: wait for tx_ready=1, then pulse tx_start for one cycle with tx_data.
  - TX_WAIT_LOW: wait for tx_ready=0.
  - TX_WAIT_HIGH: wait for tx_ready=1.
  - If bytes remain: TX_GAP for TX_GAP cycles, then the next TX_LOAD. Otherwise DONE.
- DONE: one cycle; frames_received<=0; go to IDLE. mul_enable is level-sampled again in IDLE.
- Overrun: an rx_valid rising edge in any busy state other than RX sets err_overrun; the byte is ignored.
- mul_enable deassertion mid-transaction has no effect.
- Operand registers are cleared on entry to RX.

Test Plan:
- OP_WIDTH=8, unsigned multiply, bytes 0x0C, 0x0A -> result=0x000078, result_valid pulse; tx bytes 0x78, 0x00 separated by at least TX_GAP cycles; busy low afterwards.
- Signed multiply, bytes 0xFF, 0x02 -> product 0xFFFE (-2), result=0xFFFFFE (sign-extended to ACC_WIDTH); tx bytes 0xFE, 0xFF; MUL-to-ACC latency exactly 9 cycles.
- acc_clear, then two unsigned multiply-accumulate transactions of 0xFF, 0xFF -> result 0x00FE01 then 0x01FC02; second tx sequence 0x02, 0xFC, 0x01; acc_overflow=0. With ACC_GUARD=0 -> result wraps to 0xFC02, acc_overflow=1, cleared by the next acc_clear in IDLE.
- RX_TIMEOUT=20: one byte 0x33, then 21 silent cycles -> err_timeout=1, still in RX; then 0x04, 0x05 -> product 0x0014.
- rx_valid edge during TX -> err_overrun=1, tx bytes unchanged; reset=0 mid-TX_WAIT_HIGH -> next cycle all outputs 0, state IDLE; rx_valid held high through reset produces no phantom byte.
- OP_WIDTH=16, unsigned multiply, bytes 0x34, 0x12, 0x02, 0x00 -> 0x1234*0x0002 = 0x00002468; tx bytes 0x68, 0x24, 0x00, 0x00.

Source files
------------

// File: rtl/mul_frame_engine.sv
// Byte-stream multiply / multiply-accumulate engine: operand bytes in, shift-add core, result bytes out LSB first.
// Latency DELAY_CYCLES+OP_WIDTH+2 cycles from last operand byte to result_valid; TX stalls on tx_ready, bytes TX_GAP apart.
module mul_frame_engine #(
  parameter int  OP_WIDTH     = 8,
  parameter int  ACC_GUARD    = 8,
  parameter int  DELAY_CYCLES = 100,
  parameter int  TX_GAP       = 1000,
  parameter int  RX_TIMEOUT   = 50000,
  localparam int ACC_WIDTH    = 2*OP_WIDTH + ACC_GUARD
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 mul_enable,
  input  logic [1:0]           mode,
  input  logic                 acc_clear,
  input  logic                 rx_valid,
  input  logic [7:0]           rx_data,
  input  logic                 tx_ready,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  output logic                 frames_received,
  output logic                 busy,
  output logic [ACC_WIDTH-1:0] result,
  output logic                 result_valid,
  output logic                 acc_overflow,
  output logic                 err_timeout,
  output logic                 err_overrun
);

  localparam int OP_BYTES  = OP_WIDTH / 8;
  localparam int RX_BYTES  = 2 * OP_BYTES;
  localparam int ACC_BYTES = ACC_WIDTH / 8;
  localparam int PW        = 2 * OP_WIDTH;
  localparam int IW        = $clog2(RX_BYTES + 1);
  localparam int TW        = $clog2(ACC_BYTES + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_RX, S_DELAY, S_MUL, S_SIGN, S_ACC,
    S_TX_LOAD, S_TX_WAIT_LOW, S_TX_WAIT_HIGH, S_TX_GAP, S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [1:0]           mode_q, mode_d;
  logic                 rx_prev_q, rx_prev_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [PW-1:0]        ops_q, ops_d;
  logic [31:0]          cnt_q, cnt_d;
  logic [PW-1:0]        mcand_q, mcand_d;
  logic [OP_WIDTH-1:0]  mplier_q, mplier_d;
  logic [PW-1:0]        prod_q, prod_d;
  logic                 neg_q, neg_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [ACC_WIDTH-1:0] tx_shift_q, tx_shift_d;
  logic [TW-1:0]        tx_left_q, tx_left_d;
  logic                 tx_start_q, tx_start_d;
  logic [7:0]           tx_data_q, tx_data_d;
  logic                 frames_q, frames_d;
  logic                 busy_q, busy_d;
  logic [ACC_WIDTH-1:0] result_q, result_d;
  logic                 result_valid_q, result_valid_d;
  logic                 acc_ovf_q, acc_ovf_d;
  logic                 err_timeout_q, err_timeout_d;
  logic                 err_overrun_q, err_overrun_d;

  logic                 rx_edge;
  logic [OP_WIDTH-1:0]  op_a, op_b, mag_a, mag_b;
  logic [ACC_WIDTH-1:0] prod_ext;
  logic [ACC_WIDTH:0]   acc_sum;
  logic                 sum_ovf;

  always_comb begin
    rx_edge  = rx_valid & ~rx_prev_q;
    op_a     = ops_q[OP_WIDTH-1:0];
    op_b     = ops_q[PW-1:OP_WIDTH];
    mag_a    = (mode_q[1] && op_a[OP_WIDTH-1]) ? -op_a : op_a;
    mag_b    = (mode_q[1] && op_b[OP_WIDTH-1]) ? -op_b : op_b;
    prod_ext = mode_q[1] ? ACC_WIDTH'($signed(prod_q)) : ACC_WIDTH'(prod_q);
    acc_sum  = {1'b0, acc_q} + {1'b0, prod_ext};
    // Signed overflow: addends agree in sign but the sum does not.
    sum_ovf  = mode_q[1] ? ((acc_q[ACC_WIDTH-1] == prod_ext[ACC_WIDTH-1]) &&
                            (acc_sum[ACC_WIDTH-1] != acc_q[ACC_WIDTH-1]))
                         : acc_sum[ACC_WIDTH];
  end

  always_comb begin
    state_d        = state_q;
    mode_d         = mode_q;
    rx_prev_d      = rx_valid;
    idx_d          = idx_q;
    ops_d          = ops_q;
    cnt_d          = cnt_q;
    mcand_d        = mcand_q;
    mplier_d       = mplier_q;
    prod_d         = prod_q;
    neg_d          = neg_q;
    acc_d          = acc_q;
    tx_shift_d     = tx_shift_q;
    tx_left_d      = tx_left_q;
    tx_start_d     = 1'b0;
    tx_data_d      = tx_data_q;
    frames_d       = frames_q;
    result_d       = result_q;
    result_valid_d = 1'b0;
    acc_ovf_d      = acc_ovf_q;
    err_timeout_d  = err_timeout_q;
    err_overrun_d  = err_overrun_q;

    if (rx_edge && state_q != S_IDLE && state_q != S_RX) err_overrun_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (acc_clear) begin
          acc_d     = '0;
          acc_ovf_d = 1'b0;
        end
        if (mul_enable) begin
          mode_d        = mode;
          err_timeout_d = 1'b0;
          err_overrun_d = 1'b0;
          ops_d         = '0;
          idx_d         = '0;
          cnt_d         = '0;
          state_d       = S_RX;
        end
      end
      S_RX: begin
        if (rx_edge) begin
          for (int i = 0; i < RX_BYTES; i++) begin
            if (idx_q == IW'(i)) ops_d[i*8 +: 8] = rx_data;
          end
          cnt_d = '0;
          if (idx_q == IW'(RX_BYTES - 1)) begin
            frames_d = 1'b1;
            state_d  = S_DELAY;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end else if (RX_TIMEOUT != 0 && idx_q != '0) begin
          if (cnt_q + 32'd1 >= 32'(RX_TIMEOUT)) begin
            err_timeout_d = 1'b1;
            ops_d         = '0;
            idx_d         = '0;
            cnt_d         = '0;
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end
      end
      S_DELAY: begin
        if (cnt_q + 32'd1 >= 32'(DELAY_CYCLES)) begin
          mcand_d  = PW'(mag_a);
          mplier_d = mag_b;
          prod_d   = '0;
          neg_d    = mode_q[1] & (op_a[OP_WIDTH-1] ^ op_b[OP_WIDTH-1]);
          cnt_d    = '0;
          state_d  = S_MUL;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_MUL: begin
        if (mplier_q[0]) prod_d = prod_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        if (cnt_q + 32'd1 >= 32'(OP_WIDTH)) state_d = S_SIGN;
        else cnt_d = cnt_q + 32'd1;
      end
      S_SIGN: begin
        if (neg_q) prod_d = -prod_q;
        state_d = S_ACC;
      end
      S_ACC: begin
        if (mode_q[0]) begin
          acc_d      = acc_sum[ACC_WIDTH-1:0];
          result_d   = acc_sum[ACC_WIDTH-1:0];
          tx_shift_d = acc_sum[ACC_WIDTH-1:0];
          tx_left_d  = TW'(ACC_BYTES);
          if (sum_ovf) acc_ovf_d = 1'b1;
        end else begin
          result_d   = prod_ext;
          tx_shift_d = prod_ext;
          tx_left_d  = TW'(RX_BYTES);
        end
        result_valid_d = 1'b1;
        state_d        = S_TX_LOAD;
      end
      S_TX_LOAD: begin
        if (tx_ready) begin
          tx_start_d = 1'b1;
          tx_data_d  = tx_shift_q[7:0];
          tx_shift_d = tx_shift_q >> 8;
          tx_left_d  = tx_left_q - TW'(1);
          state_d    = S_TX_WAIT_LOW;
        end
      end
      S_TX_WAIT_LOW: begin
        if (!tx_ready) state_d = S_TX_WAIT_HIGH;
      end
      S_TX_WAIT_HIGH: begin
        if (tx_ready) begin
          if (tx_left_q == '0) begin
            state_d = S_DONE;
          end else begin
            cnt_d   = '0;
            state_d = S_TX_GAP;
          end
        end
      end
      S_TX_GAP: begin
        if (cnt_q + 32'd1 >= 32'(TX_GAP)) state_d = S_TX_LOAD;
        else cnt_d = cnt_q + 32'd1;
      end
      S_DONE: begin
        frames_d = 1'b0;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      mode_q         <= '0;
      rx_prev_q      <= rx_valid;
      idx_q          <= '0;
      ops_q          <= '0;
      cnt_q          <= '0;
      mcand_q        <= '0;
      mplier_q       <= '0;
      prod_q         <= '0;
      neg_q          <= 1'b0;
      acc_q          <= '0;
      tx_shift_q     <= '0;
      tx_left_q      <= '0;
      tx_start_q     <= 1'b0;
      tx_data_q      <= '0;
      frames_q       <= 1'b0;
      busy_q         <= 1'b0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      acc_ovf_q      <= 1'b0;
      err_timeout_q  <= 1'b0;
      err_overrun_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      mode_q         <= mode_d;
      rx_prev_q      <= rx_prev_d;
      idx_q          <= idx_d;
      ops_q          <= ops_d;
      cnt_q          <= cnt_d;
      mcand_q        <= mcand_d;
      mplier_q       <= mplier_d;
      prod_q         <= prod_d;
      neg_q          <= neg_d;
      acc_q          <= acc_d;
      tx_shift_q     <= tx_shift_d;
      tx_left_q      <= tx_left_d;
      tx_start_q     <= tx_start_d;
      tx_data_q      <= tx_data_d;
      frames_q       <= frames_d;
      busy_q         <= busy_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      acc_ovf_q      <= acc_ovf_d;
      err_timeout_q  <= err_timeout_d;
      err_overrun_q  <= err_overrun_d;
    end
  end

  assign tx_start        = tx_start_q;
  assign tx_data         = tx_data_q;
  assign frames_received = frames_q;
  assign busy            = busy_q;
  assign result          = result_q;
  assign result_valid    = result_valid_q;
  assign acc_overflow    = acc_ovf_q;
  assign err_timeout     = err_timeout_q;
  assign err_overrun     = err_overrun_q;

endmodule
